// File: rtl/calpoc_pkg.sv
// Shared types, opcode constants and the bitwise operator helper for the CalPOC calculator.
package calpoc_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned OPC_W     = 2;

    localparam logic [OPC_W-1:0] OP_NONE = 2'd0;
    localparam logic [OPC_W-1:0] OP_OR   = 2'd1;
    localparam logic [OPC_W-1:0] OP_XOR  = 2'd2;
    localparam logic [OPC_W-1:0] OP_AND  = 2'd3;

    typedef enum logic [1:0] {
        ARG1   = 2'd0,
        OP     = 2'd1,
        ARG2   = 2'd2,
        RESULT = 2'd3
    } stateT;

    // One bit per button press, highest priority first.
    typedef struct packed {
        logic clear;
        logic equals;
        logic opOr;
        logic opXor;
        logic opAnd;
        logic one;
        logic zero;
    } pressT;

    // Operands are zero-extended to MAX_WIDTH by the caller; OP_NONE passes a through.
    function automatic logic [MAX_WIDTH-1:0] apply_op(
        input logic [OPC_W-1:0]     op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] res;
        case (op)
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_AND:  res = a & b;
            default: res = a;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calpoc_btn_edge.sv
// Vector rising-edge detector; previous samples preset to 1 so buttons held through reset do not fire.
module calpoc_btn_edge #(
    parameter int unsigned N = 7
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] btnLevel,
    output logic [N-1:0] rise_c
);

    logic [N-1:0] prevSample;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prevSample <= '1;
        end else begin
            prevSample <= btnLevel;
        end
    end

    assign rise_c = btnLevel & ~prevSample;

endmodule

// File: rtl/calpoc_param_fsm.sv
// Parametrised CalPOC bitwise calculator: digit entry, OR/XOR/AND, result and operator chaining.
module calpoc_param_fsm
    import calpoc_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ButtonFor1,
    input  logic             ButtonFor0,
    input  logic             ButtonForOR,
    input  logic             ButtonForXOR,
    input  logic             ButtonForAND,
    input  logic             ButtonForEquals,
    input  logic             ButtonForClear,
    output logic [WIDTH-1:0] LEDForA,
    output logic [WIDTH-1:0] LEDForB,
    output logic [WIDTH-1:0] ResultOut,
    output logic             ResultValid,
    output logic [1:0]       OpCode,
    output logic [1:0]       StateOut,
    output logic             DigitOverflow
);

    localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
    localparam int unsigned NUM_BTN = 7;

    logic [NUM_BTN-1:0] rawBtn;
    logic [NUM_BTN-1:0] rise_c;
    pressT              press;

    stateT              state,       nextState;
    logic [WIDTH-1:0]   regA,        nextA;
    logic [WIDTH-1:0]   regB,        nextB;
    logic [WIDTH-1:0]   regResult,   nextResult;
    logic               resultValid, nextValid;
    logic [OPC_W-1:0]   opCode,      nextOpCode;
    logic [CNT_W-1:0]   cntA,        nextCntA;
    logic [CNT_W-1:0]   cntB,        nextCntB;
    logic               overflow,    nextOverflow;

    logic               isDigit;
    logic               isOp;
    logic               digitVal;
    logic [OPC_W-1:0]   pressOp;
    logic               aFull;
    logic               bFull;
    logic [WIDTH-1:0]   shiftA;
    logic [WIDTH-1:0]   shiftB;
    logic [WIDTH-1:0]   evalAB;
    logic [WIDTH-1:0]   evalA0;
    logic [WIDTH-1:0]   evalRB;

    assign rawBtn = {ButtonForClear, ButtonForEquals, ButtonForOR, ButtonForXOR,
                     ButtonForAND, ButtonFor1, ButtonFor0};

    calpoc_btn_edge #(
        .N (NUM_BTN)
    ) uBtnEdge (
        .CLK      (CLK),
        .RST      (RST),
        .btnLevel (rawBtn),
        .rise_c   (rise_c)
    );

    assign press = pressT'(rise_c);

    // Pressing 1 and 0 together cancels both digits.
    assign isDigit  = press.one ^ press.zero;
    assign digitVal = press.one;
    assign isOp     = press.opOr | press.opXor | press.opAnd;
    assign pressOp  = press.opOr  ? OP_OR  :
                      press.opXor ? OP_XOR : OP_AND;

    assign aFull  = (cntA == CNT_W'(WIDTH));
    assign bFull  = (cntB == CNT_W'(WIDTH));
    assign shiftA = WIDTH'({regA, digitVal});
    assign shiftB = WIDTH'({regB, digitVal});

    assign evalAB = WIDTH'(apply_op(opCode, MAX_WIDTH'(regA), MAX_WIDTH'(regB)));
    assign evalA0 = WIDTH'(apply_op(opCode, MAX_WIDTH'(regA), MAX_WIDTH'(0)));
    assign evalRB = WIDTH'(apply_op(opCode, MAX_WIDTH'(regResult), MAX_WIDTH'(regB)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ARG1;
            regA        <= '0;
            regB        <= '0;
            regResult   <= '0;
            resultValid <= 1'b0;
            opCode      <= OP_NONE;
            cntA        <= '0;
            cntB        <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= nextState;
            regA        <= nextA;
            regB        <= nextB;
            regResult   <= nextResult;
            resultValid <= nextValid;
            opCode      <= nextOpCode;
            cntA        <= nextCntA;
            cntB        <= nextCntB;
            overflow    <= nextOverflow;
        end
    end

    // Only the highest-priority press in a cycle acts: clear, equals, operator, digit.
    always_comb begin
        nextState    = state;
        nextA        = regA;
        nextB        = regB;
        nextResult   = regResult;
        nextValid    = resultValid;
        nextOpCode   = opCode;
        nextCntA     = cntA;
        nextCntB     = cntB;
        nextOverflow = 1'b0;

        if (press.clear) begin
            nextState  = ARG1;
            nextA      = '0;
            nextB      = '0;
            nextResult = '0;
            nextValid  = 1'b0;
            nextOpCode = OP_NONE;
            nextCntA   = '0;
            nextCntB   = '0;
        end else if (press.equals) begin
            unique case (state)
                ARG1: begin
                end
                OP: begin
                    nextResult = evalA0;
                    nextValid  = 1'b1;
                    nextState  = RESULT;
                end
                ARG2: begin
                    nextResult = evalAB;
                    nextValid  = 1'b1;
                    nextState  = RESULT;
                end
                RESULT: begin
                    nextResult = evalRB;
                end
            endcase
        end else if (isOp) begin
            unique case (state)
                ARG1, OP: begin
                    nextOpCode = pressOp;
                    nextState  = OP;
                end
                ARG2: begin
                    // Chaining folds the partial result into A, which is then full.
                    nextA      = evalAB;
                    nextCntA   = CNT_W'(WIDTH);
                    nextB      = '0;
                    nextCntB   = '0;
                    nextOpCode = pressOp;
                    nextState  = OP;
                end
                RESULT: begin
                    nextA      = regResult;
                    nextCntA   = CNT_W'(WIDTH);
                    nextB      = '0;
                    nextCntB   = '0;
                    nextOpCode = pressOp;
                    nextState  = OP;
                end
            endcase
        end else if (isDigit) begin
            unique case (state)
                ARG1: begin
                    if (aFull) begin
                        nextOverflow = 1'b1;
                    end else begin
                        nextA    = shiftA;
                        nextCntA = cntA + CNT_W'(1);
                    end
                end
                OP, ARG2: begin
                    if (bFull) begin
                        nextOverflow = 1'b1;
                    end else begin
                        nextB    = shiftB;
                        nextCntB = cntB + CNT_W'(1);
                    end
                    nextState = ARG2;
                end
                RESULT: begin
                    // A digit after a result starts a fresh calculation.
                    nextA      = WIDTH'(digitVal);
                    nextCntA   = CNT_W'(1);
                    nextB      = '0;
                    nextCntB   = '0;
                    nextOpCode = OP_NONE;
                    nextValid  = 1'b0;
                    nextState  = ARG1;
                end
            endcase
        end
    end

    assign LEDForA       = regA;
    assign LEDForB       = regB;
    assign ResultOut     = regResult;
    assign ResultValid   = resultValid;
    assign OpCode        = opCode;
    assign StateOut      = state;
    assign DigitOverflow = overflow;

endmodule
